// File: rtl/spi_miso_shifter.sv
// spi_miso_shifter
//   Serialises the read byte from the register read-data mux onto SPI MISO
//   (mode 0: MISO changes after SCLK falls, host samples on SCLK rising).
//   SCLK and CS_N are oversampled in the i_clk domain; i_clk must be at least
//   8x SCLK. Pin edge to MISO update latency is SYNC_STAGES+1 i_clk cycles.
//
// Configuration macro:
//   SPI_MISO_LSB_FIRST_EN  defined   -> bytes go out LSB first
//                          undefined -> bytes go out MSB first (default)
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_sclk       SPI clock pin (asynchronous)
//   i_cs_n       SPI chip select pin, active-low (asynchronous)
//   i_data       read byte from the read-data mux
//   i_load       1-cycle strobe: capture i_data as the next byte to send
//   o_miso       serial data to host (registered)
//   o_busy       1 while the synchronised CS_N is low
//   o_byte_done  1-cycle pulse: a byte has been fully shifted
//   o_underrun   1-cycle pulse: a byte started with no data loaded
//
// Handshake: i_load is a single-cycle strobe with no back-pressure. A load
// landing in the same cycle as a reload goes straight into the shifter;
// otherwise it is parked in the hold register (a later load overwrites it).
module spi_miso_shifter #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_BYTE   = 8'hFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sclk,
    input  logic              i_cs_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_load,
    output logic              o_miso,
    output logic              o_busy,
    output logic              o_byte_done,
    output logic              o_underrun
);

    localparam int              CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic                    sclk_prev;
    logic                    cs_prev;
    logic [DATA_W-1:0]       shift;
    logic [DATA_W-1:0]       hold;
    logic                    hold_valid;
    logic [CNT_W-1:0]        cnt;

    logic                    sclk_cur;
    logic                    cs_cur;
    logic                    fall;
    logic                    cs_start;
    logic                    last_fall;
    logic                    reload;
    logic [DATA_W-1:0]       reload_data;
    logic [DATA_W-1:0]       shifted;
    logic [DATA_W-1:0]       next_shift;
    logic                    next_bit;

    assign sclk_cur = sclk_sync[SYNC_STAGES-1];
    assign cs_cur   = cs_sync[SYNC_STAGES-1];

    always_comb begin
        fall      = sclk_prev & ~sclk_cur;
        cs_start  = cs_prev & ~cs_cur;
        last_fall = (state == SHIFT) && fall && (cnt == LAST);
        // A deasserted CS always wins: nothing reloads while idle.
        reload    = ~cs_cur & (cs_start | last_fall);

        // Same-cycle load bypasses the hold register; then held byte; then underrun filler.
        if (i_load)
            reload_data = i_data;
        else if (hold_valid)
            reload_data = hold;
        else
            reload_data = IDLE_BYTE;

`ifdef SPI_MISO_LSB_FIRST_EN
        shifted = {1'b0, shift[DATA_W-1:1]};
`else
        shifted = {shift[DATA_W-2:0], 1'b0};
`endif

        if (reload)
            next_shift = reload_data;
        else if ((state == SHIFT) && fall)
            next_shift = shifted;
        else
            next_shift = shift;

`ifdef SPI_MISO_LSB_FIRST_EN
        next_bit = next_shift[0];
`else
        next_bit = next_shift[DATA_W-1];
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            sclk_sync   <= '0;
            sclk_prev   <= 1'b0;
            cs_sync     <= '1;
            cs_prev     <= 1'b1;
            shift       <= '0;
            hold        <= '0;
            hold_valid  <= 1'b0;
            cnt         <= '0;
            o_miso      <= 1'b0;
            o_busy      <= 1'b0;
            o_byte_done <= 1'b0;
            o_underrun  <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
            sclk_prev   <= sclk_cur;
            cs_prev     <= cs_cur;
            o_byte_done <= 1'b0;
            o_underrun  <= 1'b0;

            // Hold register: consumed by a reload unless the reload took the bypass.
            if (reload) begin
                if (!i_load && hold_valid)
                    hold_valid <= 1'b0;
            end else if (i_load) begin
                hold       <= i_data;
                hold_valid <= 1'b1;
            end

            if (cs_cur) begin
                // CS high: any partial byte is dropped, hold is left alone.
                state  <= IDLE;
                cnt    <= '0;
                o_miso <= 1'b0;
                o_busy <= 1'b0;
            end else begin
                o_busy <= 1'b1;
                shift  <= next_shift;
                o_miso <= next_bit;
                if (reload) begin
                    state       <= SHIFT;
                    cnt         <= '0;
                    o_byte_done <= last_fall & ~cs_start;
                    o_underrun  <= ~i_load & ~hold_valid;
                end else if ((state == SHIFT) && fall) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_miso_shifter.sv
// tb_spi_miso_shifter
//   Directed bench for spi_miso_shifter with i_clk = 16x SCLK. The host side
//   is modelled by tasks; expected MISO bits are queued when a byte is
//   loaded / expected and popped on every SCLK rising edge. Note that the
//   fall closing the final byte of a burst reloads from an empty hold
//   register, so each burst ends with exactly one trailing underrun pulse.
module tb_spi_miso_shifter;

    localparam int W = 8;

    logic         i_clk;
    logic         i_rst;
    logic         i_sclk;
    logic         i_cs_n;
    logic [W-1:0] i_data;
    logic         i_load;
    logic         o_miso;
    logic         o_busy;
    logic         o_byte_done;
    logic         o_underrun;

    int checks = 0;
    int errors = 0;
    int bd_cnt = 0;
    int ur_cnt = 0;
    int bd0;
    int ur0;
    int bit_idx = 0;
    logic [0:0] exp_q[$];
    logic [W-1:0] rnd [3];

    spi_miso_shifter dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sclk      (i_sclk),
        .i_cs_n      (i_cs_n),
        .i_data      (i_data),
        .i_load      (i_load),
        .o_miso      (o_miso),
        .o_busy      (o_busy),
        .o_byte_done (o_byte_done),
        .o_underrun  (o_underrun)
    );

    // Clock / reset block
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Pulse counters, sampled on the falling edge away from the active edge.
    always @(negedge i_clk) begin
        if (o_byte_done) bd_cnt = bd_cnt + 1;
        if (o_underrun)  ur_cnt = ur_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        errors = errors + 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic push_byte(input logic [W-1:0] b);
        for (int i = 0; i < W; i++) begin
`ifdef SPI_MISO_LSB_FIRST_EN
            exp_q.push_back(b[i]);
`else
            exp_q.push_back(b[W-1-i]);
`endif
        end
    endtask

    task automatic load_byte(input logic [W-1:0] b);
        i_data = b;
        i_load = 1'b1;
        @(negedge i_clk);
        i_load = 1'b0;
    endtask

    // n SCLK periods; MISO is checked just before each rising edge. When
    // b == byp_bit, i_load is pulsed in the exact cycle the fall is seen
    // (two synchroniser stages after the pin fall).
    task automatic spi_bits(input int n, input int byp_bit, input logic [W-1:0] byp_data);
        logic [0:0] exp;
        for (int b = 0; b < n; b++) begin
            wait_clks(8);
            check("exp_q_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check($sformatf("miso_bit%0d", bit_idx), o_miso, exp);
            end
            bit_idx = bit_idx + 1;
            i_sclk = 1'b1;
            wait_clks(8);
            i_sclk = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                @(negedge i_clk);
                if (b == byp_bit && k == 2) begin
                    i_data = byp_data;
                    i_load = 1'b1;
                end
                if (k == 3) i_load = 1'b0;
            end
        end
    endtask

    task automatic cs_low();
        bd0 = bd_cnt;
        ur0 = ur_cnt;
        i_cs_n = 1'b0;
        wait_clks(4);
    endtask

    task automatic cs_high();
        i_cs_n = 1'b1;
        wait_clks(6);
        check("idle_busy", o_busy, 0);
        check("idle_miso", o_miso, 0);
    endtask

    initial begin
        i_rst  = 1'b1;
        i_sclk = 1'b0;
        i_cs_n = 1'b1;
        i_data = '0;
        i_load = 1'b0;
        wait_clks(3);
        check("rst_miso", o_miso, 0);
        check("rst_busy", o_busy, 0);
        check("rst_byte_done", o_byte_done, 0);
        check("rst_underrun", o_underrun, 0);
        i_rst = 1'b0;
        wait_clks(4);
        check("post_rst_busy", o_busy, 0);

        // Preloaded byte.
        load_byte(8'hA5);
        push_byte(8'hA5);
        cs_low();
        check("t1_busy", o_busy, 1);
        check("t1_no_start_underrun", ur_cnt - ur0, 0);
        spi_bits(8, -1, '0);
        check("t1_byte_done", bd_cnt - bd0, 1);
        check("t1_trailing_underrun", ur_cnt - ur0, 1);
        cs_high();

        // Nothing loaded: IDLE_BYTE goes out, underrun at CS fall.
        push_byte(8'hFF);
        cs_low();
        check("t2_start_underrun", ur_cnt - ur0, 1);
        spi_bits(8, -1, '0);
        check("t2_byte_done", bd_cnt - bd0, 1);
        check("t2_underrun_total", ur_cnt - ur0, 2);
        cs_high();

        // Back-to-back: second byte loaded while the first is shifting.
        load_byte(8'hA5);
        push_byte(8'hA5);
        push_byte(8'h3C);
        cs_low();
        spi_bits(4, -1, '0);
        load_byte(8'h3C);
        spi_bits(12, -1, '0);
        check("t3_byte_done", bd_cnt - bd0, 2);
        check("t3_underrun", ur_cnt - ur0, 1);
        cs_high();

        // Bypass: load lands in the reload cycle with hold empty.
        load_byte(8'hA5);
        push_byte(8'hA5);
        push_byte(8'h81);
        cs_low();
        spi_bits(8, 7, 8'h81);
        spi_bits(8, -1, '0);
        check("t4_byte_done", bd_cnt - bd0, 2);
        check("t4_underrun", ur_cnt - ur0, 1);
        cs_high();

        // Abort after 3 bits, then a fresh byte from bit 7.
        load_byte(8'hA5);
        push_byte(8'hA5);
        cs_low();
        spi_bits(3, -1, '0);
        repeat (5) void'(exp_q.pop_front());
        cs_high();
        check("t5_abort_no_byte_done", bd_cnt - bd0, 0);
        load_byte(8'h5A);
        push_byte(8'h5A);
        cs_low();
        check("t5_no_underrun", ur_cnt - ur0, 0);
        spi_bits(8, -1, '0);
        check("t5_byte_done", bd_cnt - bd0, 1);
        cs_high();

        // Reset mid-byte.
        load_byte(8'h3C);
        push_byte(8'h3C);
        cs_low();
        spi_bits(3, -1, '0);
        i_sclk = 1'b1;
        wait_clks(4);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("t6_rst_miso", o_miso, 0);
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_byte_done", o_byte_done, 0);
        check("t6_rst_underrun", o_underrun, 0);
        i_rst  = 1'b0;
        i_cs_n = 1'b1;
        i_sclk = 1'b0;
        exp_q.delete();
        wait_clks(6);
        check("t6_no_byte_done", bd_cnt - bd0, 0);
        check("t6_no_underrun", ur_cnt - ur0, 0);

        // Random back-to-back burst.
        for (int i = 0; i < 3; i++) rnd[i] = W'($urandom_range(0, 255));
        load_byte(rnd[0]);
        push_byte(rnd[0]);
        cs_low();
        check("t7_no_start_underrun", ur_cnt - ur0, 0);
        for (int i = 1; i < 3; i++) begin
            spi_bits(2, -1, '0);
            load_byte(rnd[i]);
            push_byte(rnd[i]);
            spi_bits(6, -1, '0);
        end
        spi_bits(8, -1, '0);
        check("t7_byte_done", bd_cnt - bd0, 3);
        check("t7_underrun", ur_cnt - ur0, 1);
        cs_high();
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
